// File: rtl/fc2_weight_loader_pkg.sv
// Shared FC2 definitions: default memory geometry and the weight-loader
// FSM state encoding. Imported by the FC2 weight loader.
package fc2_weight_loader_pkg;

  localparam int FC2_DATA_WIDTH   = 32;  // weight / bias word width
  localparam int FC2_ADDRESS_BITS = 11;  // memory write address width
  localparam int FC2_IFM_DEPTH    = 84;  // weight words per weight memory
  localparam int FC2_NUMBER_OF_WM = 10;  // weight memories (= bias words)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_WM = 2'd1,
    ST_LOAD_BM = 2'd2,
    ST_DONE    = 2'd3
  } fc2_state_e;

endpackage

// File: rtl/fc2_weight_loader.sv
// FC2 weight loader: streams weight and bias words from the RISC-V side
// into the FC2 weight memories (WM0..WM(N-1), IFM_DEPTH words each) and
// then the bias memory (N words). Each accepted word is written one cycle
// later through registered data/address/enable outputs.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   start           one-cycle request to begin a full load
//   in_data         incoming weight/bias word
//   in_valid        in_data valid this cycle
//   in_ready        loader accepts a word this cycle
//   riscv_data      registered write data to the FC2 memories
//   riscv_address   registered write address (zero-extended)
//   wm_enable_write one-hot weight-memory write enable
//   bm_enable_write bias-memory write enable
//   busy            load in progress
//   loaded          full parameter set written
module fc2_weight_loader
  import fc2_weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = FC2_DATA_WIDTH,
  parameter int ADDRESS_BITS = FC2_ADDRESS_BITS,
  parameter int IFM_DEPTH    = FC2_IFM_DEPTH,
  parameter int NUMBER_OF_WM = FC2_NUMBER_OF_WM
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   riscv_data,
  output logic [ADDRESS_BITS-1:0] riscv_address,
  output logic [NUMBER_OF_WM-1:0] wm_enable_write,
  output logic                    bm_enable_write,
  output logic                    busy,
  output logic                    loaded
);

  localparam int CNT_W = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam logic [CNT_W-1:0] WM_ADDR_LAST = CNT_W'(IFM_DEPTH - 1);
  localparam logic [CNT_W-1:0] BM_ADDR_LAST = CNT_W'(NUMBER_OF_WM - 1);

  fc2_state_e state_q, state_d;

  logic [CNT_W-1:0]        addr_q, addr_d;
  logic [NUMBER_OF_WM-1:0] wm_sel_q, wm_sel_d;   // one-hot weight-memory index

  logic [DATA_WIDTH-1:0]   data_q;
  logic [ADDRESS_BITS-1:0] waddr_q;
  logic [NUMBER_OF_WM-1:0] wm_en_q;
  logic                    bm_en_q;

  logic accept;
  logic wm_last_beat;
  logic bm_last_beat;

  assign accept       = in_valid & in_ready;
  assign wm_last_beat = wm_sel_q[NUMBER_OF_WM-1] && (addr_q == WM_ADDR_LAST);
  assign bm_last_beat = (addr_q == BM_ADDR_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wm_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wm_sel_q <= wm_sel_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wm_sel_d = wm_sel_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_LOAD_WM;
          addr_d   = '0;
          wm_sel_d = NUMBER_OF_WM'(1);
        end
      end
      ST_LOAD_WM: begin
        if (accept) begin
          if (addr_q == WM_ADDR_LAST) begin
            addr_d = '0;
            if (wm_last_beat) begin
              state_d = ST_LOAD_BM;
            end else begin
              wm_sel_d = wm_sel_q << 1;
            end
          end else begin
            addr_d = addr_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD_BM: begin
        if (accept) begin
          if (bm_last_beat) begin
            state_d = ST_DONE;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    loaded   = 1'b0;
    unique case (state_q)
      ST_LOAD_WM, ST_LOAD_BM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: loaded = 1'b1;
      default: ;
    endcase
  end

  // Write port register: one cycle after acceptance. Data and address hold
  // between beats; the enables alone qualify them.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      waddr_q <= '0;
      wm_en_q <= '0;
      bm_en_q <= 1'b0;
    end else begin
      wm_en_q <= (accept && state_q == ST_LOAD_WM) ? wm_sel_q : '0;
      bm_en_q <= accept && (state_q == ST_LOAD_BM);
      if (accept) begin
        data_q  <= in_data;
        waddr_q <= ADDRESS_BITS'(addr_q);
      end
    end
  end

  assign riscv_data      = data_q;
  assign riscv_address   = waddr_q;
  assign wm_enable_write = wm_en_q;
  assign bm_enable_write = bm_en_q;

endmodule

// File: tb/tb_fc2_weight_loader.sv
// Bench for fc2_weight_loader: directed scenarios with random data and
// random in_valid gaps, checked cycle by cycle against a beat-count model.
module tb_fc2_weight_loader;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int IFM   = 84;
  localparam int NWM   = 10;
  localparam int WB    = IFM * NWM;
  localparam int TOTAL = WB + NWM;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] riscv_data;
  logic [AW-1:0] riscv_address;
  logic [NWM-1:0] wm_enable_write;
  logic          bm_enable_write;
  logic          busy;
  logic          loaded;

  fc2_weight_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .riscv_data      (riscv_data),
    .riscv_address   (riscv_address),
    .wm_enable_write (wm_enable_write),
    .bm_enable_write (bm_enable_write),
    .busy            (busy),
    .loaded          (loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_count = 0;

  // Reference model: a loading flag, the index of the next beat, and the
  // last written word/address.
  bit            m_active = 0;
  bit            m_loaded = 0;
  int            m_beat = 0;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [NWM-1:0] e_wm = '0;
  logic          e_bm = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [DW-1:0] d, input logic r);
    bit acc;
    start = s; in_valid = v; in_data = d; reset = r;
    acc = !r && m_active && v;
    @(posedge clk); #1;
    e_wm = '0; e_bm = 1'b0;
    if (r) begin
      m_active = 0; m_loaded = 0; m_beat = 0; m_data = '0; m_addr = '0;
    end else if (acc) begin
      if (m_beat < WB) begin
        e_wm   = NWM'(1) << (m_beat / IFM);
        m_addr = AW'(m_beat % IFM);
      end else begin
        e_bm   = 1'b1;
        m_addr = AW'(m_beat - WB);
      end
      m_data = d;
      m_beat++;
      if (m_beat == TOTAL) begin
        m_active = 0;
        m_loaded = 1;
      end
    end else if (s && !m_active) begin
      m_active = 1; m_loaded = 0; m_beat = 0;
    end
    if (wm_enable_write != '0 || bm_enable_write) en_count++;
    chk("wm_en",  64'(wm_enable_write), 64'(e_wm));
    chk("bm_en",  64'(bm_enable_write), 64'(e_bm));
    chk("data",   64'(riscv_data), 64'(m_data));
    chk("addr",   64'(riscv_address), 64'(m_addr));
    chk("ready",  64'(in_ready), 64'(m_active));
    chk("busy",   64'(busy), 64'(m_active));
    chk("loaded", 64'(loaded), 64'(m_loaded));
    start = 1'b0; in_valid = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int b;
    int guard;

    // Reset, with start and in_valid asserted to confirm reset wins
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("rst_wm", 64'(wm_enable_write), 64'h0);
    chk("rst_loaded", 64'(loaded), 64'h0);

    // in_valid while idle is ignored
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i + 7), 1'b0);
    chk("idle_nowrite", 64'(wm_enable_write), 64'h0);

    // Back-to-back full load, in_data = beat index
    step(1'b1, 1'b0, '0, 1'b0);
    en_count = 0;
    for (b = 0; b < TOTAL; b++) begin
      step(1'b0, 1'b1, 32'(b), 1'b0);
      if (b == 84) begin
        chk("b84_wm", 64'(wm_enable_write), 64'b0000000010);
        chk("b84_addr", 64'(riscv_address), 64'd0);
      end
      if (b == 257) begin
        chk("wm3a5_wm", 64'(wm_enable_write), 64'b0000001000);
        chk("wm3a5_addr", 64'(riscv_address), 64'd5);
        chk("wm3a5_data", 64'(riscv_data), 64'd257);
      end
      if (b == 839) begin
        chk("b839_wm", 64'(wm_enable_write), 64'b1000000000);
        chk("b839_addr", 64'(riscv_address), 64'd83);
      end
      if (b == 840) begin
        chk("b840_bm", 64'(bm_enable_write), 64'd1);
        chk("b840_addr", 64'(riscv_address), 64'd0);
      end
      if (b == 849) begin
        chk("bias9_addr", 64'(riscv_address), 64'd9);
        chk("bias9_data", 64'(riscv_data), 64'd849);
        chk("b849_loaded", 64'(loaded), 64'd1);
      end
    end
    chk("enable_total", 64'(en_count), 64'd850);

    // Valid in DONE is ignored
    step(1'b0, 1'b1, 32'h1234, 1'b0);
    chk("done_nowrite", 64'(bm_enable_write), 64'd0);

    // Start in DONE: loaded drops, reload with random data and 50% gaps
    step(1'b1, 1'b0, '0, 1'b0);
    chk("restart_loaded", 64'(loaded), 64'd0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    chk("restart_wm0", 64'(wm_enable_write), 64'd1);
    chk("restart_addr0", 64'(riscv_address), 64'd0);
    guard = 0;
    en_count = 1;
    while (!m_loaded && guard < 6000) begin
      step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      guard++;
    end
    chk("rand_done", 64'(loaded), 64'd1);
    chk("rand_total", 64'(en_count), 64'd850);

    // Start pulsed mid-load at beat 100 is ignored
    step(1'b1, 1'b0, '0, 1'b0);
    for (b = 0; b < TOTAL; b++) begin
      step(b == 100, 1'b1, $urandom, 1'b0);
      if (b == 100) chk("b100_addr", 64'(riscv_address), 64'd16);
      if (b == 848) chk("b848_loaded", 64'(loaded), 64'd0);
    end
    chk("startbusy_loaded", 64'(loaded), 64'd1);

    // Reset at beat 400 aborts, then a full reload
    step(1'b1, 1'b0, '0, 1'b0);
    for (b = 0; b < 400; b++) step(1'b0, 1'b1, $urandom, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("abort_data", 64'(riscv_data), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    chk("abort_loaded", 64'(loaded), 64'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (b = 0; b < TOTAL; b++) step(1'b0, 1'b1, 32'(b), 1'b0);
    chk("reload_loaded", 64'(loaded), 64'd1);
    chk("reload_data", 64'(riscv_data), 64'd849);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc2_weight_loader.md
FC2_WEIGHT_LOADER -- requirements
Module: fc2_weight_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of weights and biases.
REQ-002 Parameter ADDRESS_BITS, default 11, width of the memory write address.
REQ-003 Parameter IFM_DEPTH, default 84, weight words per weight memory.
REQ-004 Parameter NUMBER_OF_WM, default 10, number of weight memories; also the number of bias words.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a full load sequence.
REQ-008 in_data  input  DATA_WIDTH  weight/bias word from the RISC-V side.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 riscv_data  output  DATA_WIDTH  registered write data to the FC2 memories.
REQ-012 riscv_address  output  ADDRESS_BITS  registered write address, zero-extended.
REQ-013 wm_enable_write  output  NUMBER_OF_WM  one-hot write enable, bit k selects weight memory k.
REQ-014 bm_enable_write  output  1  bias memory write enable.
REQ-015 busy  output  1  load sequence in progress.
REQ-016 loaded  output  1  complete parameter set written; FC2 may run inference.

Function
REQ-017 FSM states are IDLE, LOAD_WM, LOAD_BM and DONE.
REQ-018 Transitions: IDLE or DONE + start -> LOAD_WM with wm index 0 and address 0; LOAD_WM last beat -> LOAD_BM with address 0; LOAD_BM last beat -> DONE.
REQ-019 in_ready is 1 in LOAD_WM and LOAD_BM, else 0; a beat is accepted when in_valid and in_ready are both 1.
REQ-020 Write order is WM0 addresses 0..IFM_DEPTH-1, then WM1, ..., WM(NUMBER_OF_WM-1), then bias addresses 0..NUMBER_OF_WM-1; the total is IFM_DEPTH*NUMBER_OF_WM+NUMBER_OF_WM beats (850 at default).
REQ-021 An accepted beat drives riscv_data, riscv_address and exactly one enable for exactly the following cycle (latency 1); with no accepted beat, all enables are 0.
REQ-022 Address wrap: in LOAD_WM, a beat at address IFM_DEPTH-1 resets the address to 0 and advances the wm index; the index never exceeds NUMBER_OF_WM-1.
REQ-023 The last LOAD_WM beat is wm index NUMBER_OF_WM-1 at address IFM_DEPTH-1; the last LOAD_BM beat is at address NUMBER_OF_WM-1.
REQ-024 in_valid gaps stall the counters without limit and emit no writes.
REQ-025 start while busy is ignored: the counters and state are unchanged.
REQ-026 start in DONE clears loaded in the next cycle and restarts at WM0 address 0.
REQ-027 in_valid in IDLE or DONE is ignored and causes no write.
REQ-028 busy is 1 exactly in LOAD_WM and LOAD_BM; loaded is 1 exactly in DONE, rising in the cycle after the last bias write is issued.
REQ-029 riscv_data holds its last value when no beat is accepted; only the enables qualify it.

Reset
REQ-030 reset forces IDLE; in_ready, wm_enable_write, bm_enable_write, busy and loaded become 0; riscv_data, riscv_address and the internal counters become 0.
REQ-031 reset during LOAD_WM or LOAD_BM aborts the sequence with no further writes; a partial load never sets loaded.
REQ-032 reset has priority over start and in_valid in the same cycle.

Structure
REQ-033 A shared FC2 package holds DATA_WIDTH, ADDRESS_BITS, IFM_DEPTH and NUMBER_OF_WM and the FSM state enumeration.
REQ-034 The block is a single module with no sub-modules; the address counter is $clog2(IFM_DEPTH) bits wide and the wm index is a one-hot shift register.

Verification
REQ-035 Scenario: reset, then start, then 850 back-to-back beats with in_data = beat index -> the WM3 address 5 write carries data 257; the bias address 9 write carries data 849; loaded = 1 one cycle after the last write; 850 enables in total.
REQ-036 Scenario: in_valid toggles randomly at 50% over a full load -> the write stream is identical to the back-to-back run; no write occurs in a cycle following a non-accepted cycle.
REQ-037 Scenario: at beat 84 -> wm_enable_write = 10'b0000000010 with address 0; at beat 839 -> wm_enable_write = 10'b1000000000 with address 83; at beat 840 -> bm_enable_write = 1 with address 0.
REQ-038 Scenario: start pulsed at beat 100 -> the beat numbering is unchanged and loaded rises only after beat 849.
REQ-039 Scenario: reset asserted at beat 400 -> all outputs are 0 the next cycle; then start plus 850 beats -> a full reload completes correctly.
REQ-040 Scenario: start in DONE -> loaded = 0 the next cycle and the first write goes to WM0 address 0.
